// File: rtl/xbus_cycle_ctl.sv
// xbus_cycle_ctl: external-memory bus sequencer for the MCS-51 core.
// Turns one fetch / MOVX read / MOVX write request into a multiplexed
// P0/P2 bus cycle: ADDR (ALE high) -> HOLD -> STB (strobe low) -> REC (ACK).
// Every output is a register computed from the next state, so nothing on
// the pins depends combinationally on an input.
module xbus_cycle_ctl #(
  parameter int ALE_CYC = 2,  // clocks ALE is high, 1..7
  parameter int STB_CYC = 3   // clocks the strobe is low, 1..15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [1:0]  TYP,
  input  logic        A8,
  input  logic [15:0] ADDR,
  input  logic [7:0]  WDATA,
  input  logic [7:0]  P2SFR,
  input  logic [7:0]  P0_IN,
  output logic        ALE,
  output logic        nPSEN,
  output logic        nRD,
  output logic        nWR,
  output logic [7:0]  P0_OUT,
  output logic        P0_OE,
  output logic [7:0]  P2_OUT,
  output logic [7:0]  RDATA,
  output logic        ACK,
  output logic        BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_HOLD, S_STB, S_REC} state_t;
  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

  localparam logic [3:0] ALE_LOAD = 4'(ALE_CYC - 1);
  localparam logic [3:0] STB_LOAD = 4'(STB_CYC - 1);

  state_t      r_state;
  kind_t       r_kind;
  logic        r_a8;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [3:0]  r_cnt;

  logic        r_ale, r_npsen, r_nrd, r_nwr, r_p0_oe, r_ack, r_busy;
  logic [7:0]  r_p0_out, r_p2_out, r_rdata;

  kind_t       w_kind_in;
  logic [7:0]  w_p2_bus;

  // TYP=11 is folded into read.
  assign w_kind_in = (TYP == 2'b00) ? K_FETCH :
                     (TYP == 2'b10) ? K_WRITE : K_READ;

  // P2 source for every non-IDLE clock of a captured cycle.
  assign w_p2_bus  = r_a8 ? P2SFR : r_addr[15:8];

  // Single sequencer: state, counter and all registered pin values.
  always_ff @(posedge CLK) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // samples the pre-edge values; blocking would chain updates within one edge.
    if (RST) begin
      r_state  <= S_IDLE;
      r_kind   <= K_FETCH;
      r_a8     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_ale    <= 1'b0;
      r_npsen  <= 1'b1;
      r_nrd    <= 1'b1;
      r_nwr    <= 1'b1;
      r_p0_oe  <= 1'b0;
      r_p0_out <= 8'h00;
      r_p2_out <= 8'hFF;
      r_rdata  <= 8'h00;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_p2_out <= P2SFR;
          if (REQ) begin
            r_kind   <= w_kind_in;
            r_a8     <= A8;
            r_addr   <= ADDR;
            r_wdata  <= WDATA;
            r_cnt    <= ALE_LOAD;
            r_state  <= S_ADDR;
            r_busy   <= 1'b1;
            r_ale    <= 1'b1;
            r_p0_oe  <= 1'b1;
            r_p0_out <= ADDR[7:0];
            r_p2_out <= A8 ? P2SFR : ADDR[15:8];
          end
        end
        S_ADDR: begin
          r_p2_out <= w_p2_bus;
          if (r_cnt == '0) begin
            // Latch closes; P0 keeps the low address for one hold clock.
            r_ale   <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_p2_out <= w_p2_bus;
          r_cnt    <= STB_LOAD;
          r_state  <= S_STB;
          r_npsen  <= (r_kind != K_FETCH);
          r_nrd    <= (r_kind != K_READ);
          r_nwr    <= (r_kind != K_WRITE);
          r_p0_oe  <= (r_kind == K_WRITE);
          r_p0_out <= (r_kind == K_WRITE) ? r_wdata : 8'h00;
        end
        S_STB: begin
          r_p2_out <= w_p2_bus;
          if (r_cnt == '0) begin
            // Strobe rises; write data stays on P0 through REC for hold time.
            r_npsen <= 1'b1;
            r_nrd   <= 1'b1;
            r_nwr   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_REC;
            if (r_kind != K_WRITE) r_rdata <= P0_IN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_REC: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_p0_oe  <= 1'b0;
          r_p0_out <= 8'h00;
          r_p2_out <= P2SFR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ALE    = r_ale;
  assign nPSEN  = r_npsen;
  assign nRD    = r_nrd;
  assign nWR    = r_nwr;
  assign P0_OUT = r_p0_out;
  assign P0_OE  = r_p0_oe;
  assign P2_OUT = r_p2_out;
  assign RDATA  = r_rdata;
  assign ACK    = r_ack;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_xbus_cycle_ctl.sv
// Bench for xbus_cycle_ctl: two instances (default timing and ALE_CYC=1 /
// STB_CYC=1). Stimulus pushes expected transactions into per-instance queues;
// a negedge monitor per instance pops at each cycle start and compares the
// pins clock by clock against a timing model of the bus cycle.
module tb_xbus_cycle_ctl;

  typedef struct {
    int         kind;  // 0 fetch, 1 read, 2 write
    logic [7:0] a_lo;
    logic [7:0] p2;
    logic [7:0] wd;
    logic [7:0] rd;
    int         gap;   // required clocks since previous start, 0 = don't care
  } txn_t;

  localparam logic [22:0] RST_VEC = {1'b0, 3'b111, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0};

  logic        CLK;
  logic        rst_m, rst_f, req_m, req_f;
  logic [1:0]  TYP;
  logic        A8;
  logic [15:0] ADDR;
  logic [7:0]  WDATA, P2SFR, P0_IN;

  logic       ale_m, npsen_m, nrd_m, nwr_m, oe_m, ack_m, busy_m;
  logic [7:0] p0o_m, p2o_m, rdata_m;
  logic       ale_f, npsen_f, nrd_f, nwr_f, oe_f, ack_f, busy_f;
  logic [7:0] p0o_f, p2o_f, rdata_f;

  xbus_cycle_ctl u_main (
    .CLK(CLK), .RST(rst_m), .REQ(req_m), .TYP(TYP), .A8(A8), .ADDR(ADDR),
    .WDATA(WDATA), .P2SFR(P2SFR), .P0_IN(P0_IN), .ALE(ale_m), .nPSEN(npsen_m),
    .nRD(nrd_m), .nWR(nwr_m), .P0_OUT(p0o_m), .P0_OE(oe_m), .P2_OUT(p2o_m),
    .RDATA(rdata_m), .ACK(ack_m), .BUSY(busy_m)
  );

  xbus_cycle_ctl #(.ALE_CYC(1), .STB_CYC(1)) u_fast (
    .CLK(CLK), .RST(rst_f), .REQ(req_f), .TYP(TYP), .A8(A8), .ADDR(ADDR),
    .WDATA(WDATA), .P2SFR(P2SFR), .P0_IN(P0_IN), .ALE(ale_f), .nPSEN(npsen_f),
    .nRD(nrd_f), .nWR(nwr_f), .P0_OUT(p0o_f), .P0_OE(oe_f), .P2_OUT(p2o_f),
    .RDATA(rdata_f), .ACK(ack_f), .BUSY(busy_f)
  );

  // P0 data is compared only while driven.
  wire logic [22:0] vec_m = {ale_m, npsen_m, nrd_m, nwr_m, oe_m,
                             oe_m ? p0o_m : 8'h00, p2o_m, ack_m, busy_m};
  wire logic [22:0] vec_f = {ale_f, npsen_f, nrd_f, nwr_f, oe_f,
                             oe_f ? p0o_f : 8'h00, p2o_f, ack_f, busy_f};

  txn_t       q0[$];
  txn_t       q1[$];
  txn_t       cur[2];
  bit         active[2];
  bit         rstc[2];
  int         kcnt[2];
  int         last_start[2];
  logic [7:0] last_rd[2];
  int         cyc;
  int         n_checks;
  int         n_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin values in clock k (1..N) of a cycle, N = ac + sc + 2.
  function automatic logic [22:0] exp_vec(input txn_t t, input int k, input int ac, input int sc);
    logic       ale, stb, oe;
    logic [7:0] p0;
    ale = (k <= ac);
    stb = (k >= ac + 2) && (k <= ac + sc + 1);
    if (k <= ac + 1) begin
      oe = 1'b1; p0 = t.a_lo;
    end else if (t.kind == 2) begin
      oe = 1'b1; p0 = t.wd;
    end else begin
      oe = 1'b0; p0 = 8'h00;
    end
    return {ale, !(stb && t.kind == 0), !(stb && t.kind == 1), !(stb && t.kind == 2),
            oe, p0, t.p2, (k == ac + sc + 2), 1'b1};
  endfunction

  task automatic mon(input int i, input logic [22:0] v, input logic [7:0] rd,
                     input logic rst, input int ac, input int sc);
    int n;
    int qs;
    n = ac + sc + 2;
    if (rstc[i]) begin
      check($sformatf("rst_pins%0d", i), 32'(v), 32'(RST_VEC));
      check($sformatf("rst_rdata%0d", i), 32'(rd), 32'h00);
      rstc[i] = 1'b0;
    end else begin
      if (!active[i] && v[0]) begin
        qs = (i == 0) ? q0.size() : q1.size();
        check($sformatf("start_has_txn%0d", i), 32'(qs > 0), 32'd1);
        if (qs > 0) begin
          cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
          if (cur[i].gap > 0)
            check($sformatf("start_gap%0d", i), 32'(cyc - last_start[i]), 32'(cur[i].gap));
          last_start[i] = cyc;
          active[i] = 1'b1;
          kcnt[i] = 1;
        end
      end
      if (active[i]) begin
        check($sformatf("bus%0d_k%0d", i, kcnt[i]), 32'(v), 32'(exp_vec(cur[i], kcnt[i], ac, sc)));
        if (kcnt[i] == n) check($sformatf("rdata%0d", i), 32'(rd), 32'(cur[i].rd));
        kcnt[i]++;
        if (kcnt[i] > n) active[i] = 1'b0;
      end else begin
        check($sformatf("idle_ack_busy%0d", i), 32'(v[1:0]), 32'd0);
      end
    end
    if (rst) begin
      active[i] = 1'b0;
      rstc[i] = 1'b1;
    end
  endtask

  always @(negedge CLK) mon(0, vec_m, rdata_m, rst_m, 2, 3);
  always @(negedge CLK) mon(1, vec_f, rdata_f, rst_f, 1, 1);

  task automatic push_exp(input int i, input logic [1:0] typ, input logic a8,
                          input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] p2s, input logic [7:0] p0, input int gap);
    txn_t t;
    t.kind = (typ == 2'b00) ? 0 : (typ == 2'b10) ? 2 : 1;
    t.a_lo = addr[7:0];
    t.p2   = a8 ? p2s : addr[15:8];
    t.wd   = wd;
    if (t.kind != 2) last_rd[i] = p0;
    t.rd   = last_rd[i];
    t.gap  = gap;
    if (i == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  // Called #1 after a posedge with the instance idle; returns #1 after the
  // accepting edge (clock 1 of the cycle).
  task automatic issue(input int i, input logic [1:0] typ, input logic a8,
                       input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] p2s, input logic [7:0] p0, input bit hold);
    push_exp(i, typ, a8, addr, wd, p2s, p0, 0);
    TYP = typ; A8 = a8; ADDR = addr; WDATA = wd; P2SFR = p2s; P0_IN = p0;
    if (i == 0) req_m = 1'b1; else req_f = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) begin
      if (i == 0) req_m = 1'b0; else req_f = 1'b0;
    end
  endtask

  task automatic wait_idle(input int i);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (((i == 0) ? q0.size() : q1.size()) == 0 && !active[i] && !rstc[i]) begin
        done = 1'b1;
        break;
      end
      @(posedge CLK);
    end
    check($sformatf("drain%0d", i), 32'(done), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_err = 0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    rst_m = 1'b1; rst_f = 1'b1; req_m = 1'b0; req_f = 1'b0;
    TYP = 2'b00; A8 = 1'b0; ADDR = 16'h0000; WDATA = 8'h00; P2SFR = 8'h00; P0_IN = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    rst_m = 1'b0; rst_f = 1'b0;
    @(posedge CLK);
    #1;

    // Fetch 1234, P0 returns A5.
    issue(0, 2'b00, 1'b0, 16'h1234, 8'h00, 8'h00, 8'hA5, 1'b0);
    wait_idle(0);
    // Write via @Ri: P2 from P2SFR, RDATA keeps A5.
    issue(0, 2'b10, 1'b1, 16'h00C0, 8'h5A, 8'h7E, 8'h00, 1'b0);
    wait_idle(0);
    // TYP=11 behaves as read.
    issue(0, 2'b11, 1'b0, 16'h4321, 8'h00, 8'h00, 8'hC3, 1'b0);
    wait_idle(0);
    // Read aborted by reset during the second strobe clock (clock 5).
    issue(0, 2'b01, 1'b0, 16'h2468, 8'h00, 8'h00, 8'h99, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    rst_m = 1'b1;
    last_rd[0] = 8'h00;
    @(posedge CLK);
    #1;
    rst_m = 1'b0;
    wait_idle(0);
    // Read with REQ toggling and ADDR changing while busy.
    issue(0, 2'b01, 1'b0, 16'h1357, 8'h00, 8'h00, 8'h66, 1'b0);
    @(posedge CLK); #1; req_m = 1'b1; ADDR = 16'hFFFF;
    @(posedge CLK); #1; req_m = 1'b0;
    @(posedge CLK); #1; req_m = 1'b1; TYP = 2'b10;
    @(posedge CLK); #1; req_m = 1'b0;
    wait_idle(0);
    // Read via @Ri after the above, P2 from P2SFR.
    issue(0, 2'b01, 1'b1, 16'h0012, 8'h00, 8'h9C, 8'h0F, 1'b0);
    wait_idle(0);

    // Short timing: read FFFF twice with REQ held, starts 5 clocks apart.
    issue(1, 2'b01, 1'b0, 16'hFFFF, 8'h00, 8'h00, 8'h3C, 1'b1);
    push_exp(1, 2'b01, 1'b0, 16'hFFFF, 8'h00, 8'h00, 8'h7D, 5);
    repeat (3) @(posedge CLK);
    #1;
    P0_IN = 8'h7D;
    repeat (2) @(posedge CLK);
    #1;
    req_f = 1'b0;
    wait_idle(1);
    wait_idle(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/xbus_cycle_ctl.md
# xbus_cycle_ctl

External-memory bus sequencer for the MCS-51 core. Accepts one code-fetch, MOVX read or MOVX write request at a time from the core. Each request becomes a multiplexed P0/P2 bus cycle with ALE, nPSEN, nRD and nWR strobes. ALE also drives the enable of the board-level transparent address latch, so the low address byte is captured from P0 while ALE is high and held after ALE falls.

## Interface
- ALE_CYC, default 2: clocks ALE is held high; range 1..7.
- STB_CYC, default 3: clocks the active strobe is held low; range 1..15.
- CLK, input, 1: clock; all state changes on the rising edge.
- RST, input, 1: reset, synchronous and active-high.
- REQ, input, 1: request valid; sampled only in IDLE.
- TYP, input, 2: request type; 00 fetch, 01 read, 10 write, 11 is treated as read.
- A8, input, 1: 8-bit MOVX @Ri address mode; P2 drives P2SFR instead of ADDR[15:8].
- ADDR, input, 16: cycle address.
- WDATA, input, 8: write data.
- P2SFR, input, 8: P2 latch contents, used when A8=1 and when idle.
- P0_IN, input, 8: P0 pad input.
- ALE, output, 1: address latch enable.
- nPSEN, output, 1: program store enable, active-low.
- nRD, output, 1: data read strobe, active-low.
- nWR, output, 1: data write strobe, active-low.
- P0_OUT, output, 8: P0 drive value.
- P0_OE, output, 1: P0 output enable.
- P2_OUT, output, 8: P2 drive value.
- RDATA, output, 8: captured read or fetch data.
- ACK, output, 1: one-clock completion pulse.
- BUSY, output, 1: high in every non-IDLE state.

## Operation
- States and durations:
  - IDLE.
  - ADDR: ALE_CYC clocks.
  - HOLD: 1 clock.
  - STB: STB_CYC clocks.
  - REC: 1 clock.
- IDLE, REQ=1 at an edge: latch TYP, A8, ADDR and WDATA into internal registers, then go to ADDR. Inputs are ignored after this capture until the next IDLE.
- ADDR:
  - ALE=1, P0_OE=1, P0_OUT=addr[7:0].
  - P2_OUT=addr[15:8], or P2SFR when A8=1 (this P2 rule holds in every non-IDLE state).
  - A down-counter loaded with ALE_CYC-1 reaches 0, then go to HOLD.
- HOLD:
  - ALE=0.
  - P0 still drives addr[7:0]; this gives address hold time after the latch closes.
- STB:
  - Strobe low: nPSEN for fetch, nRD for read, nWR for write. Exactly one strobe is low.
  - Write: P0_OE=1, P0_OUT=wdata.
  - Fetch and read: P0_OE=0.
  - Counter loaded with STB_CYC-1. On the edge leaving the last STB clock, fetch and read capture P0_IN into RDATA; then go to REC.
- REC:
  - All strobes high, ACK=1.
  - Write: P0 keeps driving wdata (data hold). Fetch and read: P0_OE=0.
  - Next state is IDLE, unconditionally.
- IDLE outputs: ALE=0, strobes high, P0_OE=0, P0_OUT=00, P2_OUT=P2SFR.
- RDATA holds its value until the next fetch or read capture. Writes do not alter it.
- REQ is ignored outside IDLE. A REQ still high in the REC cycle is not a new request; it is accepted in the following IDLE clock.
- RST=1 at an edge, in any state:
  - Next cycle the block is in IDLE with ALE=0, nPSEN=nRD=nWR=1, P0_OE=0, P0_OUT=00, P2_OUT=FF, RDATA=00, ACK=0, BUSY=0.
  - An aborted cycle produces no ACK and no RDATA update.
  - Requests are ignored while RST=1.
- All outputs are registered from state; no combinational path from inputs to outputs.

## Timing
- Request accepted at edge E0. ALE rises after E0.
- Total cycle length N = ALE_CYC + STB_CYC + 2 clocks. ACK is high in clock N, BUSY is low again from clock N+1.
- Back-to-back requests have a minimum spacing of N+1 clocks, start to start.
- Defaults: 7-clock cycle.
  - ALE: clocks 1-2.
  - HOLD: clock 3.
  - Strobe low: clocks 4-6; P0 is sampled at the edge ending clock 6.
  - ACK: clock 7.
- Strobe and ALE are never high/low simultaneously. ALE falls at least 1 clock before any strobe falls. Strobes rise 1 clock before P0 write data is released.

## Test plan
- Fetch at ADDR=1234, A8=0, defaults, P0_IN=A5 during STB:
  - ALE high 2 clocks with P0_OUT=34, P2_OUT=12.
  - nPSEN low 3 clocks with P0_OE=0.
  - ACK in clock 7, RDATA=A5. nRD and nWR stay high.
- Write ADDR=00C0, WDATA=5A, A8=1, P2SFR=7E:
  - P2_OUT=7E throughout.
  - nWR low 3 clocks with P0_OUT=5A and P0_OE=1, continuing through REC.
  - RDATA unchanged.
- ALE_CYC=1, STB_CYC=1, read ADDR=FFFF, P0_IN=3C:
  - ACK in clock 4, RDATA=3C.
  - REQ held high gives the next ALE rise exactly 5 clocks after the first.
- RST asserted in the second STB clock of a read:
  - Next clock all strobes high, P0_OE=0, P2_OUT=FF, RDATA=00, BUSY=0.
  - No ACK.
- REQ toggled and ADDR changed mid-cycle:
  - Bus shows only the address captured at acceptance.
  - No second ACK; no spurious cycle.
- TYP=11: behaves exactly as read (nRD strobe, RDATA captured).
